vs_signal_mem_responder: RTL and testbench
==========================================

// Module: vs_signal_mem_responder
// PURPOSE
// - Memory-side responder for the pursuit signal (y) bus: owns the measurement vector y storage.
// - Serves the pursuit engine's combinational-address reads and writes.
// - A host loads y through a valid/ready sample stream before a pursuit run.
// - Sits between the host load path and the pursuit core's y bus.
// PARAMETERS
// - DEPTH  64 (SIGNAL_SIZE_DEFAULT)  number of y samples stored; valid addresses 0..DEPTH-1
// - AW     10 (SIGNAL_ADDR_WIDTH)    y bus address width; DEPTH <= 2**AW
// - DW     8  (DATA_BUS_WIDTH)       sample / y bus data width
// PORTS
// - clk            in   1   single clock, rising edge
// - rst            in   1   asynchronous, active-high reset
// - load_start     in   1   pulse: begin (or restart) a load of DEPTH samples
// - s_valid        in   1   host stream sample valid
// - s_data         in   DW  host stream sample
// - s_ready        out  1   responder accepts a sample this cycle
// - load_done      out  1   one-cycle pulse: final sample written
// - mem_valid      out  1   y storage holds a complete load; bus is served
// - y_write_enable in   1   y bus write strobe
// - y_write_addr   in   AW  y bus write address
// - y_write_data   in   DW  y bus write data
// - y_read_addr    in   AW  y bus read address (sampled every cycle)
// - y_read_data    out  DW  registered read data
// - y_read_valid   out  1   y_read_data is a valid response to the previous cycle's address
// - addr_err       out  1   sticky: out-of-range bus access seen since last load_start
// BEHAVIOUR
// - Reset: state IDLE, load counter 0, all outputs 0. Storage contents are not reset.
// - FSM states: IDLE -> LOAD -> READY.
//   - load_start in any state -> LOAD next cycle; counter 0; mem_valid 0; addr_err 0.
//   - load_start during LOAD aborts the load and restarts at address 0.
// - LOAD:
//   - s_ready=1 (registered, i.e. high from the first LOAD cycle); stream beat when s_valid&&s_ready.
//   - Each beat writes mem[cnt] and increments cnt. s_valid low stalls with no timeout.
//   - The beat with cnt==DEPTH-1 moves to READY. In the next cycle: load_done=1 for 1 cycle,
//     mem_valid=1, s_ready=0.
// - Outside LOAD: s_ready=0 and s_data is ignored.
// - READY, reads:
//   - Every cycle: y_read_data <= mem[y_read_addr]; y_read_valid <= 1. Latency 1 cycle.
//   - y_read_addr >= DEPTH: y_read_data <= 0, y_read_valid <= 1, addr_err <= 1.
// - READY, writes:
//   - y_write_enable with addr < DEPTH writes mem[addr] at the clock edge.
//   - y_write_enable with addr >= DEPTH: write dropped, addr_err <= 1.
// - IDLE/LOAD: bus writes ignored with no error; y_read_valid=0; y_read_data holds its last value.
// - Same-cycle load_start and bus write in READY: load_start wins, write dropped, no addr_err.
// - Read/write to the same address in the same cycle: see CONFIGURATION.
// - Reset mid-load: returns to IDLE, mem_valid 0. A new load_start is required.
// CONFIGURATION
// - VS_Y_RESP_BYPASS_EN defined: same-cycle read of the address being written returns
//   y_write_data (new data).
// - VS_Y_RESP_BYPASS_EN undefined: the same case returns the old stored value (read-first).
//   No forwarding mux is built.
// TESTING
// - Reset, then load_start, then 64 beats with s_data=i, s_valid always high
//   -> load_done pulses exactly once, 65 cycles after the load_start cycle; mem_valid=1.
// - After load, drive y_read_addr=5, 6, 63 on consecutive cycles
//   -> y_read_data = 5, 6, 63 one cycle later each; y_read_valid=1.
// - Write addr 10 = 8'hA5 while reading addr 10 in the same cycle
//   -> with bypass 8'hA5, without bypass 8'h0A; the next-cycle read returns 8'hA5.
// - Read addr 64 and write addr 100
//   -> y_read_data=0, addr_err=1 and stays 1; mem unchanged; addr_err clears on load_start.
// - load_start after 20 beats, then 64 beats of 8'hFF
//   -> all 64 addresses read 8'hFF; exactly one load_done, at the end of the second load.
// - s_valid toggled 1,0,1,0,... during load, plus a write attempt in LOAD
//   -> 128 cycles to complete; write ignored; addr_err=0.

Source files
------------

// File: rtl/vs_signal_mem_responder_if.sv
// Bundled host-load stream and pursuit y-bus signals for vs_signal_mem_responder.
// master = host/pursuit side driving requests, slave = the responder.
interface vs_signal_mem_responder_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          load_start;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          load_done;
  logic          mem_valid;
  logic          y_write_enable;
  logic [AW-1:0] y_write_addr;
  logic [DW-1:0] y_write_data;
  logic [AW-1:0] y_read_addr;
  logic [DW-1:0] y_read_data;
  logic          y_read_valid;
  logic          addr_err;

  modport master (
    output load_start, s_valid, s_data, y_write_enable, y_write_addr, y_write_data, y_read_addr,
    input  s_ready, load_done, mem_valid, y_read_data, y_read_valid, addr_err
  );

  modport slave (
    input  load_start, s_valid, s_data, y_write_enable, y_write_addr, y_write_data, y_read_addr,
    output s_ready, load_done, mem_valid, y_read_data, y_read_valid, addr_err
  );
endinterface

// File: rtl/vs_signal_mem_responder.sv
// Measurement vector y storage: host stream load, then 1-cycle-latency y-bus reads/writes.
// Optional macro VS_Y_RESP_BYPASS_EN forwards same-cycle write data to a colliding read.
module vs_signal_mem_responder #(
  parameter int DEPTH = 64,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  vs_signal_mem_responder_if.slave   bus
);

  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic          s_ready_q, s_ready_nxt;
  logic          load_done_q, load_done_nxt;
  logic          mem_valid_q, mem_valid_nxt;
  logic          addr_err_q, addr_err_nxt;

  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem [DEPTH];

  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_word;
  logic          rd_ok, wr_ok;
  logic [DW-1:0] rd_data_p1;
  logic          rd_vld_p1;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  assign rd_ok  = in_range(bus.y_read_addr);
  assign wr_ok  = in_range(bus.y_write_addr);
  assign rd_idx = bus.y_read_addr[IW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      s_ready_q   <= 1'b0;
      load_done_q <= 1'b0;
      mem_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      s_ready_q   <= s_ready_nxt;
      load_done_q <= load_done_nxt;
      mem_valid_q <= mem_valid_nxt;
      addr_err_q  <= addr_err_nxt;
    end
  end

  // load_start overrides every state and drops any concurrent bus write.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    s_ready_nxt   = s_ready_q;
    load_done_nxt = 1'b0;
    mem_valid_nxt = mem_valid_q;
    addr_err_nxt  = addr_err_q;
    mem_we        = 1'b0;
    mem_waddr     = '0;
    mem_wdata     = '0;
    if (bus.load_start) begin
      state_nxt     = LOAD;
      cnt_nxt       = '0;
      s_ready_nxt   = 1'b1;
      mem_valid_nxt = 1'b0;
      addr_err_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (bus.s_valid && s_ready_q) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = bus.s_data;
            if (cnt == LAST_IDX) begin
              state_nxt     = READY;
              s_ready_nxt   = 1'b0;
              mem_valid_nxt = 1'b1;
              load_done_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        READY: begin
          if (bus.y_write_enable) begin
            if (wr_ok) begin
              mem_we    = 1'b1;
              mem_waddr = bus.y_write_addr[IW-1:0];
              mem_wdata = bus.y_write_data;
            end else begin
              addr_err_nxt = 1'b1;
            end
          end
          if (!rd_ok) addr_err_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef VS_Y_RESP_BYPASS_EN
  assign rd_word = (mem_we && (mem_waddr == rd_idx)) ? mem_wdata : mem[rd_idx];
`else
  assign rd_word = mem[rd_idx];
`endif

  // Stage p1: registered read response; data holds outside READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
      rd_vld_p1  <= 1'b0;
    end else if (state == READY && !bus.load_start) begin
      rd_data_p1 <= rd_ok ? rd_word : '0;
      rd_vld_p1  <= 1'b1;
    end else begin
      rd_vld_p1  <= 1'b0;
    end
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.load_done    = load_done_q;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.addr_err     = addr_err_q;
  assign bus.y_read_data  = rd_data_p1;
  assign bus.y_read_valid = rd_vld_p1;

endmodule

// File: tb/tb_vs_signal_mem_responder.sv
// Randomized self-checking bench for vs_signal_mem_responder against an array-based y model.
module tb_vs_signal_mem_responder;

  localparam int DEPTH = 64;
  localparam int AW    = 10;
  localparam int DW    = 8;
`ifdef VS_Y_RESP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;

  vs_signal_mem_responder_if #(.AW(AW), .DW(DW)) bus ();

  vs_signal_mem_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] m_mem [DEPTH];
  int            m_idx;
  bit            m_err;
  logic [DW-1:0] m_last_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    bus.s_valid    = 1'b0;
    tick();
    bus.load_start = 1'b0;
    m_idx = 0;
    m_err = 1'b0;
    check_val("start_s_ready", bus.s_ready, 1);
    check_val("start_mem_valid", bus.mem_valid, 0);
    check_val("start_addr_err", bus.addr_err, 0);
    check_val("start_load_done", bus.load_done, 0);
  endtask

  // vmode: 0 always valid, 1 toggle 1/0, 2 random; dmode: 0 index, 1 all-ones, 2 random.
  task automatic feed(input int nmax, input int vmode, input int dmode, input bit wr_try,
                      output int ticks, output int done_at);
    logic          v;
    logic [DW-1:0] d;
    bit            fin;
    ticks   = 0;
    done_at = 0;
    while (m_idx < nmax && ticks < 1000) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((ticks % 2) == 0) : 1'($urandom_range(0, 1));
      d = (dmode == 0) ? DW'(m_idx) : (dmode == 1) ? 8'hFF : DW'($urandom);
      bus.s_valid        = v;
      bus.s_data         = d;
      bus.y_write_enable = wr_try && (ticks == 10);
      bus.y_write_addr   = 2;
      bus.y_write_data   = 8'h5A;
      tick();
      ticks++;
      bus.y_write_enable = 1'b0;
      if (v) begin
        m_mem[m_idx] = d;
        m_idx++;
      end
      fin = v && (m_idx == DEPTH);
      check_val("load_done", bus.load_done, fin);
      check_val("s_ready", bus.s_ready, m_idx < DEPTH);
      check_val("mem_valid", bus.mem_valid, fin);
      check_val("load_rd_valid", bus.y_read_valid, 0);
      check_val("load_rd_hold", bus.y_read_data, m_last_rd);
      check_val("load_addr_err", bus.addr_err, 0);
      if (bus.load_done && done_at == 0) done_at = ticks;
    end
    bus.s_valid = 1'b0;
    if (ticks >= 1000) check_val("load_timeout", 0, 1);
  endtask

  task automatic read_cycle(input logic [AW-1:0] ra, input bit we,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [DW-1:0] exp;
    if (ra >= DEPTH) begin
      exp   = '0;
      m_err = 1'b1;
    end else if (BYPASS && we && wa == ra) begin
      exp = wd;
    end else begin
      exp = m_mem[int'(ra)];
    end
    if (we) begin
      if (wa < DEPTH) m_mem[int'(wa)] = wd;
      else m_err = 1'b1;
    end
    bus.y_read_addr    = ra;
    bus.y_write_enable = we;
    bus.y_write_addr   = wa;
    bus.y_write_data   = wd;
    tick();
    bus.y_write_enable = 1'b0;
    m_last_rd = exp;
    check_val("rd_data", bus.y_read_data, exp);
    check_val("rd_valid", bus.y_read_valid, 1);
    check_val("addr_err", bus.addr_err, m_err);
    check_val("rdy_load_done", bus.load_done, 0);
    check_val("rdy_mem_valid", bus.mem_valid, 1);
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a++) read_cycle(AW'(a), 1'b0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, done_at;
    rst                = 1'b1;
    bus.load_start     = 1'b0;
    bus.s_valid        = 1'b0;
    bus.s_data         = '0;
    bus.y_write_enable = 1'b0;
    bus.y_write_addr   = '0;
    bus.y_write_data   = '0;
    bus.y_read_addr    = '0;
    m_last_rd          = '0;
    m_err              = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_val("rst_s_ready", bus.s_ready, 0);
    check_val("rst_load_done", bus.load_done, 0);
    check_val("rst_mem_valid", bus.mem_valid, 0);
    check_val("rst_rd_valid", bus.y_read_valid, 0);
    check_val("rst_rd_data", bus.y_read_data, 0);
    check_val("rst_addr_err", bus.addr_err, 0);

    // Baseline load: s_data = index, valid every cycle.
    start_load();
    feed(DEPTH, 0, 0, 1'b0, ticks, done_at);
    check_val("done_cycle", done_at + 1, 65);
    read_cycle(5, 1'b0, '0, '0);
    read_cycle(6, 1'b0, '0, '0);
    read_cycle(63, 1'b0, '0, '0);

    // Same-address write and read, then re-read.
    read_cycle(10, 1'b1, 10, 8'hA5);
    check_val("collide_const", bus.y_read_data, BYPASS ? 8'hA5 : 8'h0A);
    read_cycle(10, 1'b0, '0, '0);
    check_val("after_write", bus.y_read_data, 8'hA5);

    // In-range random traffic.
    for (int i = 0; i < 150; i++)
      read_cycle(AW'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 2) == 0),
                 AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));

    // Out-of-range accesses.
    read_cycle(64, 1'b0, '0, '0);
    read_cycle(0, 1'b1, 100, 8'h33);
    for (int i = 0; i < 100; i++)
      read_cycle(AW'($urandom_range(0, 79)), ($urandom_range(0, 2) == 0),
                 AW'($urandom_range(0, 79)), DW'($urandom));
    sweep();

    // Aborted load, restart with all-ones.
    start_load();
    feed(20, 0, 2, 1'b0, ticks, done_at);
    check_val("abort_no_done", done_at, 0);
    start_load();
    feed(DEPTH, 0, 1, 1'b0, ticks, done_at);
    check_val("reload_done_cycle", done_at + 1, 65);
    sweep();
    check_val("reload_ff", bus.y_read_data, 8'hFF);

    // Throttled load with an ignored bus write.
    start_load();
    feed(DEPTH, 1, 0, 1'b1, ticks, done_at);
    check_val("toggle_cycles", done_at + 1, 128);
    sweep();

    // Random-valid random-data load, then random traffic.
    start_load();
    feed(DEPTH, 2, 2, 1'b0, ticks, done_at);
    for (int i = 0; i < 120; i++)
      read_cycle(AW'($urandom_range(0, 70)), ($urandom_range(0, 1) == 0),
                 AW'($urandom_range(0, 70)), DW'($urandom));
    sweep();

    // Reset in the middle of a load.
    start_load();
    feed(10, 0, 2, 1'b0, ticks, done_at);
    rst = 1'b1;
    #2;
    check_val("midrst_s_ready", bus.s_ready, 0);
    check_val("midrst_mem_valid", bus.mem_valid, 0);
    check_val("midrst_rd_valid", bus.y_read_valid, 0);
    check_val("midrst_rd_data", bus.y_read_data, 0);
    tick();
    rst = 1'b0;
    bus.s_valid = 1'b1;
    repeat (3) tick();
    bus.s_valid = 1'b0;
    check_val("idle_s_ready", bus.s_ready, 0);
    check_val("idle_mem_valid", bus.mem_valid, 0);
    check_val("idle_rd_valid", bus.y_read_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
